masked_compress_refresh: RTL and testbench

MASKED_COMPRESS_REFRESH -- requirements
Module: masked_compress_refresh

---
 rtl/masked_compress_refresh_pkg.sv | 16 +
 rtl/masked_compress_refresh_compress_cf.sv | 30 +++
 rtl/masked_compress_refresh.sv | 94 +++++++++
 tb/tb_masked_compress_refresh.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_compress_refresh_pkg.sv
// Shared constants for the masked RECTANGLE S-box compression stages.
package masked_compress_refresh_pkg;

    localparam int unsigned MCR_NCF    = 4;   // coordinate functions per S-box
    localparam int unsigned MCR_NT     = 18;  // expanded terms per coordinate
    localparam int unsigned MCR_NSHARE = 3;   // output shares
    localparam int unsigned MCR_GRP_SZ = 6;   // terms XORed into each share

    // Term indices feeding each output share: two triples, offset by 9.
    localparam int unsigned MCR_GRP_IDX [MCR_NSHARE][MCR_GRP_SZ] = '{
        '{0, 1, 2,  9, 10, 11},
        '{3, 4, 5, 12, 13, 14},
        '{6, 7, 8, 15, 16, 17}
    };

endpackage

// File: rtl/masked_compress_refresh_compress_cf.sv
// One coordinate function: compress NT expanded terms into three shares
// and refresh them with two random bits. Purely combinational.
module compress_cf
    import masked_compress_refresh_pkg::*;
#(
    parameter int unsigned NT = MCR_NT
) (
    input  logic [NT-1:0] terms_i,
    input  logic [1:0]    r_i,
    output logic          y1_o,
    output logic          y2_o,
    output logic          y3_o
);

    logic [MCR_NSHARE-1:0] grp_par;

    // XOR each share's term group; r0 and r1 cancel across the three shares.
    always_comb begin
        grp_par = '0;
        for (int unsigned s = 0; s < MCR_NSHARE; s++) begin
            for (int unsigned j = 0; j < MCR_GRP_SZ; j++) begin
                grp_par[s] = grp_par[s] ^ terms_i[MCR_GRP_IDX[s][j]];
            end
        end
        y1_o = grp_par[0] ^ r_i[0];
        y2_o = grp_par[1] ^ r_i[1];
        y3_o = grp_par[2] ^ r_i[0] ^ r_i[1];
    end

endmodule

// File: rtl/masked_compress_refresh.sv
// Two-stage compression/refresh pipeline for a masked S-box nibble.
// Stage 1 registers terms and masks together, stage 2 registers the shares.
module masked_compress_refresh
    import masked_compress_refresh_pkg::*;
#(
    parameter int unsigned NCF = MCR_NCF,
    parameter int unsigned NT  = MCR_NT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NCF*NT-1:0]  q_in,
    input  logic               rnd_valid,
    input  logic [2*NCF-1:0]   rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NCF-1:0]     y1,
    output logic [NCF-1:0]     y2,
    output logic [NCF-1:0]     y3
);

    logic              s1_full_q, s1_full_d;
    logic              s2_full_q;
    logic [NCF*NT-1:0] q_q;
    logic [2*NCF-1:0]  rnd_q;
    logic [NCF-1:0]    y1_q, y2_q, y3_q;
    logic [NCF-1:0]    y1_c, y2_c, y3_c;
    logic              s2_adv;
    logic              accept;

    // Handshake: stage 2 advances when empty or drained; stage 1 fills
    // only when terms and fresh randomness arrive together.
    always_comb begin
        s2_adv    = !s2_full_q || out_ready;
        in_ready  = !s1_full_q || s2_adv;
        accept    = in_valid && rnd_valid && in_ready;
        s1_full_d = s1_full_q;
        if (accept) begin
            s1_full_d = 1'b1;
        end else if (s2_adv) begin
            s1_full_d = 1'b0;
        end
    end

    // Compression operates only on registered stage-1 data.
    for (genvar k = 0; k < NCF; k++) begin : g_cf
        compress_cf #(.NT(NT)) u_cf (
            .terms_i (q_q[NT*k +: NT]),
            .r_i     (rnd_q[2*k +: 2]),
            .y1_o    (y1_c[k]),
            .y2_o    (y2_c[k]),
            .y3_o    (y3_c[k])
        );
    end

    // Stage 1: glitch barrier holding terms and masks of one transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_full_q <= 1'b0;
            q_q       <= '0;
            rnd_q     <= '0;
        end else begin
            s1_full_q <= s1_full_d;
            if (accept) begin
                q_q   <= q_in;
                rnd_q <= rnd;
            end
        end
    end

    // Stage 2: output shares, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_full_q <= 1'b0;
            y1_q      <= '0;
            y2_q      <= '0;
            y3_q      <= '0;
        end else if (s2_adv) begin
            s2_full_q <= s1_full_q;
            if (s1_full_q) begin
                y1_q <= y1_c;
                y2_q <= y2_c;
                y3_q <= y3_c;
            end
        end
    end

    assign out_valid = s2_full_q;
    assign y1        = y1_q;
    assign y2        = y2_q;
    assign y3        = y3_q;

endmodule

// File: tb/tb_masked_compress_refresh.sv
// Randomized scoreboard bench for masked_compress_refresh.
module tb_masked_compress_refresh;

    localparam int NCF = 4;
    localparam int NT  = 18;

    localparam logic [3:0] SBOX [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NCF*NT-1:0] q_in = '0;
    logic              rnd_valid = 1'b0;
    logic [2*NCF-1:0]  rnd = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NCF-1:0]    y1, y2, y3;

    // Values applied at the next negedge.
    logic              in_valid_nx = 1'b0;
    logic              rnd_valid_nx = 1'b0;
    logic              out_ready_nx = 1'b0;
    logic [NCF*NT-1:0] q_nx = '0;
    logic [2*NCF-1:0]  rnd_nx = '0;
    logic [3:0]        uns_nx = '0;

    logic [15:0] sb [$];   // {unshared, y3, y2, y1}
    int n_checks = 0;
    int n_fail   = 0;
    bit last_acc;
    int n_acc;

    masked_compress_refresh #(.NCF(NCF), .NT(NT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .rnd_valid (rnd_valid),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Share k,s = parity of its six terms, then masked by r0/r1.
    function automatic logic [11:0] model_shares(input logic [NCF*NT-1:0] q, input logic [2*NCF-1:0] r);
        logic [NCF-1:0] s1, s2, s3;
        logic [17:0] t, m;
        logic [2:0] p;
        for (int k = 0; k < NCF; k++) begin
            t = q[NT*k +: NT];
            for (int s = 0; s < 3; s++) begin
                m = (18'h7 << (3*s)) | (18'h7 << (9 + 3*s));
                p[s] = ^(t & m);
            end
            s1[k] = p[0] ^ r[2*k];
            s2[k] = p[1] ^ r[2*k+1];
            s3[k] = p[2] ^ r[2*k] ^ r[2*k+1];
        end
        return {s3, s2, s1};
    endfunction

    function automatic logic [3:0] parity_all(input logic [NCF*NT-1:0] q);
        logic [3:0] v;
        for (int k = 0; k < NCF; k++) v[k] = ^q[NT*k +: NT];
        return v;
    endfunction

    // Random expansion of a nibble: each coordinate's terms XOR to its S-box bit.
    function automatic logic [NCF*NT-1:0] make_terms(input logic [3:0] nib);
        logic [NCF*NT-1:0] q;
        logic [17:0] t;
        logic [3:0] y;
        y = SBOX[nib];
        for (int k = 0; k < NCF; k++) begin
            t = 18'($urandom);
            if ((^t) != y[k]) t = t ^ (18'h1 << $urandom_range(17, 0));
            q[NT*k +: NT] = t;
        end
        return q;
    endfunction

    task automatic new_random_data();
        logic [3:0] nib;
        nib    = 4'($urandom);
        q_nx   = make_terms(nib);
        uns_nx = SBOX[nib];
    endtask

    // One cycle: apply inputs at negedge, observe 1 ns later, update scoreboard.
    task automatic step();
        @(negedge clk);
        in_valid  = in_valid_nx;
        rnd_valid = rnd_valid_nx;
        out_ready = out_ready_nx;
        q_in      = q_nx;
        rnd       = rnd_nx;
        #1;
        check("in_ready", 32'(in_ready), 32'((sb.size() < 2) || out_ready));
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'(0));
            end else begin
                check("shares", 32'({y3, y2, y1}), 32'(sb[0][11:0]));
                check("unshared", 32'(y1 ^ y2 ^ y3), 32'(sb[0][15:12]));
                if (out_ready) void'(sb.pop_front());
            end
        end
        last_acc = in_valid && rnd_valid && in_ready;
        if (last_acc) begin
            sb.push_back({uns_nx, model_shares(q_in, rnd)});
            n_acc++;
        end
    endtask

    task automatic drain(input int budget);
        int c;
        in_valid_nx  = 1'b0;
        out_ready_nx = 1'b1;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            step();
            c++;
        end
        check("drain_empty", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int sent, cyc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_y", 32'({y3, y2, y1}), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        // Single transfer, latency 2
        q_nx = '0; q_nx[0] = 1'b1; rnd_nx = '0; uns_nx = parity_all(q_nx);
        in_valid_nx = 1'b1; rnd_valid_nx = 1'b1; out_ready_nx = 1'b1;
        step();
        check("single_acc", 32'(last_acc), 32'(1));
        in_valid_nx = 1'b0;
        step();
        check("lat_cycle1", 32'(out_valid), 32'(0));
        step();
        check("lat_cycle2", 32'(out_valid), 32'(1));
        check("single_y1", 32'(y1), 32'(4'h1));
        check("single_y2", 32'(y2), 32'(0));
        check("single_y3", 32'(y3), 32'(0));
        check("single_xor", 32'(y1 ^ y2 ^ y3), 32'(4'h1));
        drain(5);

        // Refresh with r0=r1=1 on coordinate 0
        rnd_nx = 8'h03; in_valid_nx = 1'b1;
        step();
        in_valid_nx = 1'b0;
        step();
        step();
        check("refresh_valid", 32'(out_valid), 32'(1));
        check("refresh_y", 32'({y3[0], y2[0], y1[0]}), 32'(3'b010));
        check("refresh_xor", 32'(y1 ^ y2 ^ y3), 32'(4'h1));
        drain(5);

        // Randomness starvation
        in_valid_nx = 1'b1; rnd_valid_nx = 1'b0; out_ready_nx = 1'b1;
        new_random_data();
        for (int i = 0; i < 3; i++) begin
            step();
            check("starve_noacc", 32'(out_valid), 32'(0));
        end
        in_valid_nx = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("starve_after", 32'(out_valid), 32'(0));
        end

        // Backpressure: 4 transfers, out_ready low for 5 cycles
        rnd_valid_nx = 1'b1; out_ready_nx = 1'b0; in_valid_nx = 1'b1;
        sent = 0;
        new_random_data(); rnd_nx = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            step();
            if (last_acc) begin sent++; new_random_data(); rnd_nx = 8'($urandom); end
        end
        check("bp_held", 32'(sent), 32'(2));
        check("bp_in_ready", 32'(in_ready), 32'(0));
        check("bp_out_valid", 32'(out_valid), 32'(1));
        out_ready_nx = 1'b1;
        cyc = 0;
        while (sent < 4 && cyc < 20) begin
            step();
            if (last_acc) begin sent++; new_random_data(); rnd_nx = 8'($urandom); end
            cyc++;
        end
        check("bp_sent", 32'(sent), 32'(4));
        drain(10);

        // Full-rate burst
        in_valid_nx = 1'b1; rnd_valid_nx = 1'b1; out_ready_nx = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            new_random_data(); rnd_nx = 8'($urandom);
            step();
        end
        check("burst_acc", 32'(n_acc), 32'(20));
        drain(10);

        // Reset with both stages full
        in_valid_nx = 1'b1; out_ready_nx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            new_random_data(); rnd_nx = 8'($urandom);
            step();
        end
        check("mid_fill", 32'(sb.size()), 32'(2));
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'(0));
        check("mid_rst_y", 32'({y3, y2, y1}), 32'(0));
        check("mid_rst_ready", 32'(in_ready), 32'(1));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        in_valid_nx = 1'b0; out_ready_nx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle", 32'(out_valid), 32'(0));
        end

        // Random regression
        sent = 0; cyc = 0;
        new_random_data();
        while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
            in_valid_nx  = (sent < 10000) && ($urandom_range(9, 0) < 8);
            rnd_valid_nx = ($urandom_range(9, 0) < 9);
            out_ready_nx = ($urandom_range(3, 0) != 0);
            rnd_nx       = 8'($urandom);
            step();
            if (last_acc) begin sent++; new_random_data(); end
            cyc++;
        end
        check("regress_sent", 32'(sent), 32'(10000));
        check("regress_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
